// File: rtl/irq_ctrl_pkg.sv
// Shared types and helpers for the interrupt front-end.
// Optional feature macro: IRQ_CTRL_GLITCH_FILTER_EN (per-line glitch filter).
package irq_ctrl_pkg;

  localparam int N_IRQ_DEFAULT = 16;

  // Per-line request state: waiting for an event, request outstanding, handler running.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SERV = 2'd2
  } line_state_e;

  // Width of a counter able to hold 0..filt_cycles.
  function automatic int cnt_width(input int filt_cycles);
    return $clog2(filt_cycles + 1);
  endfunction

endpackage

// File: rtl/irq_line.sv
// One interrupt line: synchronizer, optional glitch filter, edge/level event
// detection, request FSM, missed-event and sticky overrun tracking.
// Optional feature macro: IRQ_CTRL_GLITCH_FILTER_EN.
//
// Handshake: o_irq stays high from event until i_eoi is seen high; the line
// re-arms only once i_eoi drops again.
module irq_line
  import irq_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b1,
  parameter int FILT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_pad,
  input  logic       i_eoi,
  output logic       o_irq,
  output logic       o_overrun,
  output logic [1:0] o_state
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("irq_line: SYNC_STAGES must be 2 or more");
  end
  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("irq_line: FILT_CYCLES must be 1 or more");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic                   w_f;
  logic                   r_prev;
  logic                   w_ev_raw;
  logic                   r_ev;
  line_state_e            r_state;
  line_state_e            w_state_nxt;
  logic                   r_missed;
  logic                   w_missed_nxt;
  logic                   w_miss_seen;
  logic                   r_overrun;
  logic                   w_overrun_nxt;
  logic                   r_irq;

  // Metastability synchronizer; the last stage is the usable line value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
  end

  assign w_s = r_sync[SYNC_STAGES-1];

`ifdef IRQ_CTRL_GLITCH_FILTER_EN
  localparam int CW = cnt_width(FILT_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          r_filt;

  // Filtered value follows s only after s has disagreed for FILT_CYCLES cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (w_s != r_filt) begin
      if (r_cnt == CW'(FILT_CYCLES - 1)) begin
        r_filt <= w_s;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_f = r_filt;
`else
  assign w_f = w_s;
`endif

  // Edge lines fire on a 0->1 of f; level lines fire whenever f is high.
  assign w_ev_raw = EDGE ? (w_f & ~r_prev) : w_f;

  // Edge history and registered event.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prev <= 1'b0;
      r_ev   <= 1'b0;
    end else begin
      r_prev <= w_f;
      r_ev   <= w_ev_raw;
    end
  end

  // Next-state, missed and overrun logic for the request FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_missed_nxt  = r_missed;
    w_overrun_nxt = r_overrun;
    w_miss_seen   = r_missed;
    case (r_state)
      ST_IDLE: begin
        if (r_ev) w_state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (i_eoi) w_state_nxt = ST_SERV;
      end
      ST_SERV: begin
        // An edge during service is remembered once; a second one is lost.
        if (EDGE && r_ev) begin
          if (r_missed) w_overrun_nxt = 1'b1;
          w_miss_seen = 1'b1;
        end
        w_missed_nxt = w_miss_seen;
        if (!i_eoi) begin
          w_missed_nxt = 1'b0;
          if (w_miss_seen || (!EDGE && w_f)) w_state_nxt = ST_PEND;
          else                               w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, flags and the registered request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_missed  <= 1'b0;
      r_overrun <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_missed  <= w_missed_nxt;
      r_overrun <= w_overrun_nxt;
      r_irq     <= (w_state_nxt == ST_PEND);
    end
  end

  assign o_irq     = r_irq;
  assign o_overrun = r_overrun;
  assign o_state   = r_state;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt front-end for the core's irq input: one independent irq_line per
// interrupt line, no priority logic. dbg_state exposes every line FSM.
// Optional feature macro: IRQ_CTRL_GLITCH_FILTER_EN (per-line glitch filter).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int               N_IRQ       = N_IRQ_DEFAULT,
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0] EDGE_MASK   = {N_IRQ{1'b1}},
  parameter int               FILT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_IRQ-1:0]      irq_pad,
  input  logic [N_IRQ-1:0]      eoi,
  output logic [N_IRQ-1:0]      irq,
  output logic [N_IRQ-1:0]      irq_overrun,
  output logic [N_IRQ-1:0][1:0] dbg_state
);

  for (genvar g = 0; g < N_IRQ; g++) begin : g_line
    irq_line #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE        (EDGE_MASK[g]),
      .FILT_CYCLES (FILT_CYCLES)
    ) u_line (
      .clk       (clk),
      .rstn      (rstn),
      .i_pad     (irq_pad[g]),
      .i_eoi     (eoi[g]),
      .o_irq     (irq[g]),
      .o_overrun (irq_overrun[g]),
      .o_state   (dbg_state[g])
    );
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: reset checks, a vector table, hand-written
// corner sequences and randomized traffic against a latency-queue model.
module tb_irq_ctrl;

  localparam int          N            = 16;
  localparam logic [15:0] TB_EDGE_MASK = 16'hFFDF;   // line 5 is level-triggered

  logic                clk = 1'b0;
  logic                rstn;
  logic [N-1:0]        irq_pad;
  logic [N-1:0]        eoi;
  logic [N-1:0]        irq;
  logic [N-1:0]        irq_overrun;
  logic [N-1:0][1:0]   dbg_state;

  // clock
  always #5 clk = ~clk;

  irq_ctrl #(
    .N_IRQ       (N),
    .SYNC_STAGES (2),
    .EDGE_MASK   (TB_EDGE_MASK),
    .FILT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .irq_pad     (irq_pad),
    .eoi         (eoi),
    .irq         (irq),
    .irq_overrun (irq_overrun),
    .dbg_state   (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // Pad values seen at each sampling edge; a pad change at edge k becomes
  // an event at edge k+3, and the level-exit test looks at the pad from k-2.
  logic [15:0] m_hist[$];
  int          m_ph[N];       // 0 waiting, 1 request outstanding, 2 in service
  bit          m_missed[N];
  logic [15:0] m_irq;
  logic [15:0] m_ovr;

  function automatic void model_reset();
    m_hist = {16'h0, 16'h0, 16'h0, 16'h0};
    for (int i = 0; i < N; i++) begin
      m_ph[i]     = 0;
      m_missed[i] = 1'b0;
    end
    m_irq = '0;
    m_ovr = '0;
  endfunction

  function automatic void model_step(input logic [15:0] pad, input logic [15:0] e);
    logic [15:0] p2, p3, p4;
    bit ev;
    m_hist.push_back(pad);
    while (m_hist.size() > 5) void'(m_hist.pop_front());
    p2 = m_hist[2];
    p3 = m_hist[1];
    p4 = m_hist[0];
    for (int i = 0; i < N; i++) begin
      ev = TB_EDGE_MASK[i] ? (p3[i] && !p4[i]) : p3[i];
      if (m_ph[i] == 0) begin
        if (ev) m_ph[i] = 1;
      end else if (m_ph[i] == 1) begin
        if (e[i]) m_ph[i] = 2;
      end else begin
        if (TB_EDGE_MASK[i] && ev) begin
          if (m_missed[i]) m_ovr[i] = 1'b1;
          m_missed[i] = 1'b1;
        end
        if (!e[i]) begin
          m_ph[i]     = (m_missed[i] || (!TB_EDGE_MASK[i] && p2[i])) ? 1 : 0;
          m_missed[i] = 1'b0;
        end
      end
      m_irq[i] = (m_ph[i] == 1);
    end
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic [15:0] pad, input logic [15:0] e);
    irq_pad = pad;
    eoi     = e;
    @(posedge clk);
    model_step(pad, e);
    #1;
  endtask

  task automatic run(input logic [15:0] pad, input logic [15:0] e, input int n);
    repeat (n) tick(pad, e);
  endtask

  typedef struct {
    logic [15:0] pad;
    logic [15:0] eoi;
    logic [15:0] exp_irq;
    logic [15:0] exp_ovr;
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input logic [15:0] p, input logic [15:0] e,
                         input logic [15:0] xi, input logic [15:0] xo);
    vec_t v;
    v.pad = p; v.eoi = e; v.exp_irq = xi; v.exp_ovr = xo;
    vt.push_back(v);
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  localparam logic [15:0] M3 = 16'h0008;
  localparam logic [15:0] L5 = 16'h0020;
  localparam logic [15:0] R7 = 16'h0080;

  initial begin
    logic [15:0] rp, re;
    irq_pad = '0;
    eoi     = '0;
    rstn    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_irq", irq, 16'h0000);
    check("reset_ovr", irq_overrun, 16'h0000);
    check("reset_state", dbg_state, 32'h0);
    rstn = 1'b1;
    model_reset();

`ifdef IRQ_CTRL_GLITCH_FILTER_EN
    // 3-cycle pulse must be rejected.
    run(16'h0001, 16'h0, 3);
    run(16'h0000, 16'h0, 12);
    check("filt_short_pulse", irq, 16'h0000);
    // 4-cycle pulse passes after 2 + 1 + 4 edges.
    for (int k = 0; k < 7; k++) begin
      tick((k < 4) ? 16'h0001 : 16'h0000, 16'h0);
      check($sformatf("filt_lat_e%0d", k), irq, 16'h0000);
    end
    tick(16'h0000, 16'h0);
    check("filt_lat_e7", irq, 16'h0001);
`else
    // ---- table: edge line 0 round trip, then all lines at once ----
    add_vec(16'h0001, 16'h0000, 16'h0000, 16'h0);
    add_vec(16'h0001, 16'h0000, 16'h0000, 16'h0);
    add_vec(16'h0001, 16'h0000, 16'h0000, 16'h0);
    add_vec(16'h0001, 16'h0000, 16'h0001, 16'h0);
    add_vec(16'h0000, 16'h0000, 16'h0001, 16'h0);
    add_vec(16'h0000, 16'h0001, 16'h0000, 16'h0);
    add_vec(16'h0000, 16'h0001, 16'h0000, 16'h0);
    add_vec(16'h0000, 16'h0000, 16'h0000, 16'h0);
    add_vec(16'h0000, 16'h0000, 16'h0000, 16'h0);
    add_vec(16'h0000, 16'h0000, 16'h0000, 16'h0);
    add_vec(16'hFFFF, 16'h0000, 16'h0000, 16'h0);
    add_vec(16'h0000, 16'h0000, 16'h0000, 16'h0);
    add_vec(16'h0000, 16'h0000, 16'h0000, 16'h0);
    add_vec(16'h0000, 16'h0000, 16'hFFFF, 16'h0);
    add_vec(16'h0000, 16'h0000, 16'hFFFF, 16'h0);
    add_vec(16'h0000, 16'h00FF, 16'hFF00, 16'h0);
    add_vec(16'h0000, 16'h00FF, 16'hFF00, 16'h0);
    add_vec(16'h0000, 16'h0000, 16'hFF00, 16'h0);
    add_vec(16'h0000, 16'hFF00, 16'h0000, 16'h0);
    add_vec(16'h0000, 16'h0000, 16'h0000, 16'h0);
    add_vec(16'h0000, 16'h0000, 16'h0000, 16'h0);
    foreach (vt[i]) begin
      tick(vt[i].pad, vt[i].eoi);
      check($sformatf("tbl_irq[%0d]", i), irq, vt[i].exp_irq);
      check($sformatf("tbl_ovr[%0d]", i), irq_overrun, vt[i].exp_ovr);
    end

    // ---- edge line 3: missed event, then overrun ----
    run(M3, 16'h0, 1);
    run(16'h0, 16'h0, 3);
    check("l3_irq_set", irq, M3);
    run(16'h0, M3, 1);
    check("l3_ack", irq, 16'h0000);
    run(M3, M3, 1);
    run(16'h0, M3, 4);
    check("l3_missed_no_ovr", irq_overrun, 16'h0000);
    run(M3, M3, 1);
    run(16'h0, M3, 4);
    check("l3_ovr_set", irq_overrun, M3);
    check("l3_irq_in_serv", irq, 16'h0000);
    run(16'h0, 16'h0, 1);
    check("l3_rearm", irq, M3);
    run(16'h0, 16'h0, 3);
    check("l3_rearm_hold", irq, M3);
    run(16'h0, M3, 1);
    check("l3_ack2", irq, 16'h0000);
    run(16'h0, 16'h0, 1);
    check("l3_once", irq, 16'h0000);
    run(16'h0, 16'h0, 4);
    check("l3_idle", irq, 16'h0000);
    check("l3_ovr_sticky", irq_overrun, M3);

    // ---- level line 5 ----
    run(L5, 16'h0, 4);
    check("l5_irq_set", irq, L5);
    run(L5, L5, 1);
    check("l5_ack", irq, 16'h0000);
    run(L5, L5, 2);
    run(L5, 16'h0, 1);
    check("l5_reassert", irq, L5);
    run(L5, L5, 1);
    check("l5_ack2", irq, 16'h0000);
    run(16'h0, L5, 4);
    run(16'h0, 16'h0, 1);
    check("l5_to_idle", irq, 16'h0000);
    run(16'h0, 16'h0, 4);
    check("l5_stay_idle", irq, 16'h0000);

    // ---- reset while line 7 is in service with a missed event ----
    run(R7, 16'h0, 1);
    run(16'h0, 16'h0, 3);
    check("l7_irq_set", irq, R7);
    run(16'h0, R7, 1);
    run(R7, R7, 1);
    run(16'h0, R7, 4);
    irq_pad = R7;
    rstn    = 1'b0;
    #1;
    check("rst_mid_irq", irq, 16'h0000);
    check("rst_mid_ovr", irq_overrun, 16'h0000);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    eoi  = '0;
    model_reset();
    run(R7, 16'h0, 3);
    check("l7_after_rst_wait", irq, 16'h0000);
    run(R7, 16'h0, 1);
    check("l7_after_rst", irq, R7);
    run(16'h0, R7, 1);
    run(16'h0, 16'h0, 4);
    check("l7_idle", irq, 16'h0000);

    // ---- randomized traffic against the model ----
    rp = '0;
    re = '0;
    for (int c = 0; c < 400; c++) begin
      rp = rp ^ 16'($urandom & $urandom);
      re = re ^ 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) rp = 16'($urandom);
      tick(rp, re);
      check("rand_irq", irq, m_irq);
      check("rand_ovr", irq_overrun, m_ovr);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
